// File: rtl/dcache_responder_pkg.sv
// Shared types for the data cache responder: request commands and FSM states.
package CACHE;

   // Commands issued by the memory pipeline; CMD_IDLE means no request.
   typedef enum logic [1:0] {
      CMD_IDLE  = 2'd0,
      CMD_READ  = 2'd1,
      CMD_WRITE = 2'd2,
      CMD_FLUSH = 2'd3
   } cache_cmd_t;

   // Responder FSM states; exported on a debug port of the top.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_WMEM = 2'd2,
      ST_RESP = 2'd3
   } dcache_state_t;

endpackage

// File: rtl/dcache_responder_if.sv
// Pipeline-to-cache request bus plus the word-wide backing-memory port.
//
// Handshake semantics:
//   Request side: a command other than CMD_IDLE on ca_req_cmd acts as "valid".
//   The initiator holds cmd/addr/data stable until the cycle in which
//   ca_respcyc is 1; that single cycle is the completion.
//   Memory side: mem_req acts as "valid" and stays high, with mem_we/mem_addr/
//   mem_wdata stable, until the cycle in which mem_ack is 1 (the "ready").
//   mem_ack may be high in the very first mem_req cycle; mem_rdata is only
//   meaningful alongside mem_ack on a read.
interface dcache_responder_if;
   import CACHE::*;

   cache_cmd_t  ca_req_cmd;
   logic [63:0] ca_req_addr;
   logic [63:0] ca_req_data;
   logic        ca_respcyc;
   logic [63:0] ca_resp_data;
   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_ack;
   logic [63:0] mem_rdata;

   // Cache side.
   modport slave (
      input  ca_req_cmd, ca_req_addr, ca_req_data, mem_ack, mem_rdata,
      output ca_respcyc, ca_resp_data, mem_req, mem_we, mem_addr, mem_wdata
   );

   // Pipeline and memory side.
   modport master (
      output ca_req_cmd, ca_req_addr, ca_req_data, mem_ack, mem_rdata,
      input  ca_respcyc, ca_resp_data, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dcache_array.sv
// Direct-mapped line storage: valid bits (reset), tags and data (not reset).
// Combinational read, one write port that also sets valid, one valid-clear port.
module dcache_array #(
   parameter int unsigned IDX_W = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [IDX_W-1:0]    rd_idx,
   output logic                rd_valid,
   output logic [60-IDX_W:0]   rd_tag,
   output logic [63:0]         rd_data,
   input  logic                wr_en,
   input  logic [IDX_W-1:0]    wr_idx,
   input  logic [60-IDX_W:0]   wr_tag,
   input  logic [63:0]         wr_data,
   input  logic                clr_en,
   input  logic [IDX_W-1:0]    clr_idx
);
   localparam int unsigned LINES = 1 << IDX_W;
   localparam int unsigned TAG_W = 61 - IDX_W;

   logic [LINES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [63:0]      data_q [LINES];

   // Next valid vector: a clear and a fill never target the same cycle.
   always_comb begin
      valid_d = valid_q;
      if (clr_en) valid_d[clr_idx] = 1'b0;
      if (wr_en)  valid_d[wr_idx]  = 1'b1;
   end

   // Valid bits are the only reset state of the array.
   always_ff @(posedge clk) begin
      if (reset) valid_q <= '0;
      else       valid_q <= valid_d;
   end

   // Tag and data storage written on fills and write-throughs.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_idx]  <= wr_tag;
         data_q[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_data  = data_q[rd_idx];
endmodule

// File: rtl/dcache_responder.sv
// Write-through, direct-mapped, one-word-per-line data cache responder.
// One request in flight; misses and every write go to the backing port.
module dcache_responder
   import CACHE::*;
#(
   parameter int unsigned IDX_W = 6,
   parameter int unsigned CNT_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   dcache_responder_if.slave   bus,
   output logic [CNT_W-1:0]    hit_cnt,
   output logic [CNT_W-1:0]    miss_cnt,
   output dcache_state_t       state_o
);
   localparam int unsigned TAG_W = 61 - IDX_W;

   dcache_state_t    state_q, state_d;
   logic [63:0]      addr_q, addr_d;
   logic [63:0]      wdata_q, wdata_d;
   logic [63:0]      resp_data_q, resp_data_d;
   logic [CNT_W-1:0] hit_q, hit_d;
   logic [CNT_W-1:0] miss_q, miss_d;

   logic [IDX_W-1:0] req_idx, line_idx;
   logic [TAG_W-1:0] req_tag, line_tag;
   logic             rd_valid, hit;
   logic [TAG_W-1:0] rd_tag;
   logic [63:0]      rd_data;
   logic             wr_en, clr_en;
   logic [63:0]      wr_data;

   // Lookup uses the live request; the line update uses the address latched at acceptance.
   assign req_idx  = bus.ca_req_addr[3+IDX_W-1:3];
   assign req_tag  = bus.ca_req_addr[63:3+IDX_W];
   assign line_idx = addr_q[3+IDX_W-1:3];
   assign line_tag = addr_q[63:3+IDX_W];
   assign hit      = rd_valid && (rd_tag == req_tag);

   // A reset landing on the ack cycle must not leave a half-written line.
   assign wr_en   = !reset && bus.mem_ack && (state_q == ST_FILL || state_q == ST_WMEM);
   assign wr_data = (state_q == ST_FILL) ? bus.mem_rdata : wdata_q;
   assign clr_en  = !reset && (state_q == ST_IDLE) && (bus.ca_req_cmd == CMD_FLUSH) && hit;

   dcache_array #(.IDX_W(IDX_W)) u_array (
      .clk      (clk),
      .reset    (reset),
      .rd_idx   (req_idx),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (wr_en),
      .wr_idx   (line_idx),
      .wr_tag   (line_tag),
      .wr_data  (wr_data),
      .clr_en   (clr_en),
      .clr_idx  (req_idx)
   );

   // Next-state, request capture, response data and counter updates.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      resp_data_d = resp_data_q;
      hit_d       = hit_q;
      miss_d      = miss_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.ca_req_cmd != CMD_IDLE) begin
               addr_d      = bus.ca_req_addr & ~64'h7;
               wdata_d     = bus.ca_req_data;
               resp_data_d = '0;
               case (bus.ca_req_cmd)
                  CMD_READ: begin
                     if (hit) begin
                        resp_data_d = rd_data;
                        hit_d       = hit_q + CNT_W'(1);
                        state_d     = ST_RESP;
                     end else begin
                        miss_d  = miss_q + CNT_W'(1);
                        state_d = ST_FILL;
                     end
                  end
                  CMD_WRITE: state_d = ST_WMEM;
                  CMD_FLUSH: state_d = ST_RESP;
                  default:   state_d = ST_IDLE;
               endcase
            end
         end
         ST_FILL: begin
            if (bus.mem_ack) begin
               resp_data_d = bus.mem_rdata;
               state_d     = ST_RESP;
            end
         end
         ST_WMEM: begin
            if (bus.mem_ack) state_d = ST_RESP;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         resp_data_q <= '0;
         hit_q       <= '0;
         miss_q      <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         resp_data_q <= resp_data_d;
         hit_q       <= hit_d;
         miss_q      <= miss_d;
      end
   end

   assign bus.ca_respcyc   = (state_q == ST_RESP);
   assign bus.ca_resp_data = resp_data_q;
   assign bus.mem_req      = (state_q == ST_FILL) || (state_q == ST_WMEM);
   assign bus.mem_we       = (state_q == ST_WMEM);
   assign bus.mem_addr     = addr_q;
   assign bus.mem_wdata    = wdata_q;
   assign hit_cnt          = hit_q;
   assign miss_cnt         = miss_q;
   assign state_o          = state_q;
endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: directed scenarios followed by random traffic,
// checked against a line-level cache model and a word-addressed memory image.
module tb_dcache_responder;
   import CACHE::*;

   localparam int IDX_W = 6;
   localparam int CNT_W = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dcache_responder_if bus();
   logic [CNT_W-1:0] hit_cnt, miss_cnt;
   dcache_state_t    state_o;

   dcache_responder #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt),
      .state_o  (state_o)
   );

   // ---------------- reference model ----------------
   bit          m_valid [int];
   logic [63:0] m_line  [int];           // word address held by each index
   logic [63:0] mem_img [logic [63:0]];  // backing memory, word addressed
   int          exp_hit, exp_miss;
   logic [63:0] exp_q [$];
   int          n_checks, n_fail;

   function automatic logic [63:0] mem_read(logic [63:0] wa);
      if (mem_img.exists(wa)) return mem_img[wa];
      return {wa[31:0] ^ 32'hA5A5_0F0F, ~wa[31:0]};
   endfunction

   function automatic int line_of(logic [63:0] wa);
      return int'((wa >> 3) & ((64'd1 << IDX_W) - 64'd1));
   endfunction

   // ---------------- scoreboard ----------------
   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- driver ----------------
   task automatic do_req(cache_cmd_t cmd, logic [63:0] addr, logic [63:0] data, int ack_dly);
      logic [63:0] wa, obs_data, s_addr, s_wdata;
      int idx, lat, wcnt;
      bit is_hit, exp_mem, got, saw_req, s_we;

      wa      = addr & ~64'h7;
      idx     = line_of(wa);
      is_hit  = m_valid.exists(idx) && m_valid[idx] && (m_line[idx] == wa);
      exp_mem = (cmd == CMD_WRITE) || (cmd == CMD_READ && !is_hit);
      exp_q.push_back((cmd == CMD_READ) ? mem_read(wa) : 64'h0);

      @(negedge clk);
      bus.ca_req_cmd  = cmd;
      bus.ca_req_addr = addr;
      bus.ca_req_data = data;
      got = 0; lat = 0; wcnt = 0; saw_req = 0; s_we = 0; s_addr = '0; s_wdata = '0; obs_data = '0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(posedge clk);
         @(negedge clk);
         bus.mem_ack = 1'b0;
         if (bus.ca_respcyc) begin
            got      = 1;
            lat      = c + 1;
            obs_data = bus.ca_resp_data;
         end else if (bus.mem_req) begin
            saw_req = 1;
            s_we    = bus.mem_we;
            s_addr  = bus.mem_addr;
            s_wdata = bus.mem_wdata;
            if (wcnt == ack_dly) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = mem_read(wa);
            end
            wcnt++;
         end
      end
      bus.ca_req_cmd = CMD_IDLE;
      bus.mem_ack    = 1'b0;

      chk("resp_seen", 64'(got), 64'd1);
      chk("resp_latency", 64'(lat), exp_mem ? 64'(ack_dly + 2) : 64'd1);
      chk("resp_data", obs_data, exp_q.pop_front());
      chk("mem_req_seen", 64'(saw_req), 64'(exp_mem));
      if (exp_mem) begin
         chk("mem_we", 64'(s_we), 64'(cmd == CMD_WRITE));
         chk("mem_addr", s_addr, wa);
         if (cmd == CMD_WRITE) chk("mem_wdata", s_wdata, data);
      end

      case (cmd)
         CMD_READ: begin
            if (is_hit) exp_hit++;
            else begin
               exp_miss++;
               m_valid[idx] = 1;
               m_line[idx]  = wa;
            end
         end
         CMD_WRITE: begin
            mem_img[wa]  = data;
            m_valid[idx] = 1;
            m_line[idx]  = wa;
         end
         CMD_FLUSH: if (is_hit) m_valid[idx] = 0;
         default: ;
      endcase

      @(negedge clk);
      chk("resp_one_cycle", 64'(bus.ca_respcyc), 64'd0);
      chk("hit_cnt", 64'(hit_cnt), 64'(exp_hit));
      chk("miss_cnt", 64'(miss_cnt), 64'(exp_miss));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [63:0] a;
      int sel;
      n_checks = 0; n_fail = 0; exp_hit = 0; exp_miss = 0;
      reset = 1'b1;
      bus.ca_req_cmd = CMD_IDLE; bus.ca_req_addr = '0; bus.ca_req_data = '0;
      bus.mem_ack = 1'b0; bus.mem_rdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_respcyc", 64'(bus.ca_respcyc), 64'd0);
      chk("rst_resp_data", bus.ca_resp_data, 64'd0);
      chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
      chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
      chk("rst_mem_addr", bus.mem_addr, 64'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 64'd0);
      chk("rst_hit_cnt", 64'(hit_cnt), 64'd0);
      chk("rst_miss_cnt", 64'(miss_cnt), 64'd0);
      chk("rst_state", 64'(state_o), 64'(ST_IDLE));
      reset = 1'b0;

      // Directed scenarios.
      mem_img[64'h1000] = 64'h1122334455667788;
      do_req(CMD_READ,  64'h1000, 64'h0, 3);
      chk("first_miss_cnt", 64'(miss_cnt), 64'd1);
      do_req(CMD_READ,  64'h1000, 64'h0, 0);
      chk("first_hit_cnt", 64'(hit_cnt), 64'd1);
      do_req(CMD_WRITE, 64'h1000, 64'hDEADBEEF, 1);
      do_req(CMD_READ,  64'h1005, 64'h0, 0);
      do_req(CMD_READ,  64'h1200, 64'h0, 2);
      do_req(CMD_READ,  64'h1000, 64'h0, 0);
      do_req(CMD_FLUSH, 64'h3000, 64'h0, 0);
      do_req(CMD_READ,  64'h1000, 64'h0, 0);
      do_req(CMD_FLUSH, 64'h1000, 64'h0, 0);
      do_req(CMD_READ,  64'h1000, 64'h0, 1);
      do_req(CMD_FLUSH, 64'h1000, 64'h0, 0);

      // Reset arriving in the middle of a fill.
      @(negedge clk);
      bus.ca_req_cmd = CMD_READ; bus.ca_req_addr = 64'h1000;
      @(posedge clk); @(negedge clk);
      chk("fill_mem_req", 64'(bus.mem_req), 64'd1);
      @(posedge clk); @(negedge clk);
      reset = 1'b1; bus.ca_req_cmd = CMD_IDLE;
      @(posedge clk); @(negedge clk);
      chk("rst_fill_mem_req", 64'(bus.mem_req), 64'd0);
      chk("rst_fill_respcyc", 64'(bus.ca_respcyc), 64'd0);
      chk("rst_fill_hit_cnt", 64'(hit_cnt), 64'd0);
      chk("rst_fill_miss_cnt", 64'(miss_cnt), 64'd0);
      reset = 1'b0;
      m_valid.delete(); exp_hit = 0; exp_miss = 0;
      @(posedge clk); @(negedge clk);
      bus.mem_ack = 1'b1; bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      @(posedge clk); @(negedge clk);
      bus.mem_ack = 1'b0;
      chk("stray_ack_respcyc", 64'(bus.ca_respcyc), 64'd0);
      chk("stray_ack_mem_req", 64'(bus.mem_req), 64'd0);
      @(negedge clk);
      chk("stray_ack_respcyc2", 64'(bus.ca_respcyc), 64'd0);
      do_req(CMD_READ, 64'h1000, 64'h0, 0);
      chk("post_rst_miss_cnt", 64'(miss_cnt), 64'd1);

      // Random traffic over a few conflicting indices and tags.
      for (int n = 0; n < 150; n++) begin
         a = (64'($urandom_range(0, 2)) << (3 + IDX_W)) | (64'($urandom_range(0, 3)) << 3)
             | 64'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) a = a | 64'h8000_0000_0000_0000;
         sel = $urandom_range(0, 9);
         if (sel < 5)      do_req(CMD_READ,  a, 64'h0, $urandom_range(0, 3));
         else if (sel < 8) do_req(CMD_WRITE, a, {$urandom, $urandom}, $urandom_range(0, 3));
         else              do_req(CMD_FLUSH, a, 64'h0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
